sap_sequencer: RTL and testbench
================================

Name: sap_sequencer

Overview:
- Parametrised microcode sequencer for the SAP-1 CPU; next generation of the fixed six-step controller.
- Generates the 16-bit control word from the T-state counter, the opcode from the instruction register, and the carry/zero flags.
- Adds variable-length instructions with early counter reset, conditional jumps (JC/JZ), a latched halt state and a run-enable stall input.
- Sits between the instruction/flag registers and all datapath load/output enables.

Parameters:
- MAX_STEPS, 5, number of T-states per instruction when FIXED_LEN=1; also sizes the step counter; legal values are 5 or more.
- FIXED_LEN, 0, 1 = every instruction runs to step MAX_STEPS-1 (legacy timing); 0 = counter returns to 0 after the opcode's last step.
- HALT_ON_UNKNOWN, 0, 1 = opcodes 9..D behave as HLT; 0 = they behave as NOP.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- en  input  1  run enable; 0 stalls the sequencer.
- opcode  input  4  instruction register upper nibble.
- carry_f  input  1  registered carry flag.
- zero_f  input  1  registered zero flag.
- out  output  16  control word. Bit assignment: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
- step  output  clog2(MAX_STEPS)  current T-state.
- instr_done  output  1  high during the last step of the current instruction.
- halted  output  1  halt latch.

Behaviour:
- Reset (rst=0 at a clock edge): step=0, halted=0. Output values after reset: out=16'h4004 (CO|MI), instr_done=0.
- out, instr_done: combinational from step, opcode, flags, en and halted.
- en=0 or halted=1: out=0 and instr_done=0, with one exception: halted=1 forces out=16'h8000. The step counter holds.
- Fetch (all opcodes):
  - T0: CO|MI.
  - T1: RO|II|CE.
  - The opcode is valid from T2 onward. The last step is never earlier than T2.
- Execute words and last step per opcode:
  - LDA 1: T2 IO|MI; T3 RO|AI; last step 3.
  - ADD 2: T2 IO|MI; T3 RO|BI; T4 EO|AI|FI; last step 4.
  - SUB 3: same as ADD, with SU also set at T4; last step 4.
  - STA 4: T2 IO|MI; T3 AO|RI; last step 3.
  - LDI 5: T2 IO|AI; last step 2.
  - JMP 6: T2 IO|J; last step 2.
  - JC 7: T2 IO|J if carry_f=1, otherwise 0; last step 2.
  - JZ 8: T2 IO|J if zero_f=1, otherwise 0; last step 2.
  - OUT E: T2 AO|OI; last step 2.
  - HLT F: T2 HLT; last step 2.
  - NOP 0 and opcodes 9..D: T2 = 0; last step 2. With HALT_ON_UNKNOWN=1, opcodes 9..D are treated as HLT instead.
  - Any step beyond the last step (FIXED_LEN=1 only): out=0.
- Counter on a clock edge with en=1 and halted=0:
  - FIXED_LEN=0: if step equals the opcode's last step, step<=0; otherwise step<=step+1.
  - FIXED_LEN=1: wraps from MAX_STEPS-1 to 0.
  - instr_done follows the same end condition, except that with FIXED_LEN=1 it marks step MAX_STEPS-1.
- Halt: a clock edge with en=1, step=2 and a HLT opcode (including unknown opcodes when HALT_ON_UNKNOWN=1) sets halted<=1. step stays at 2. Only reset clears halted.
- Reset mid-instruction: on the next clock edge, step returns to 0 and halted clears, regardless of en.
- Flags are sampled combinationally at T2 only. A flag change at any other step has no effect.

Test Plan:
- Reset then run LDA (opcode=1) with en=1 → step sequence 0,1,2,3,0. out sequence 4004, 1408, 4800, 1200. instr_done high at step 3 only.
- ADD (opcode=2) → T4 out=0281 (EO|AI|FI). SUB (opcode=3) → T4 out=02C1. Both return to step 0 after step 4.
- JC with carry_f=0 → T2 out=0000. Then JC with carry_f=1 → T2 out=0802. JZ with zero_f=1 → T2 out=0802. Each returns to step 0 after step 2.
- HLT (opcode=F) → T2 out=8000, then halted=1. step stays 2 and out stays 8000 for 10 cycles. Assert rst=0 for one edge → step=0, halted=0, out=4004.
- en=0 at step 3 of STA for 4 cycles → out=0000 and step stays 3. Release en → out=2100 (AO|RI), then step 0.
- FIXED_LEN=1, MAX_STEPS=6, opcode=6 → steps 0..5 then wrap to 0. out=0000 at steps 3..5. instr_done high at step 5. Also assert rst=0 mid-instruction at step 4 → step=0 on the next edge.

Source files
------------

// File: rtl/sap_sequencer.sv
// Microcode sequencer for the SAP-1 CPU: decodes T-state, opcode and flags into the
// 16-bit control word, with variable-length instructions, conditional jumps and halt latch.
module sap_sequencer #(
    parameter int unsigned MAX_STEPS       = 5,
    parameter bit          FIXED_LEN       = 1'b0,
    parameter bit          HALT_ON_UNKNOWN = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [3:0]                   opcode,
    input  logic                         carry_f,
    input  logic                         zero_f,
    output logic [15:0]                  out,
    output logic [$clog2(MAX_STEPS)-1:0] step,
    output logic                         instr_done,
    output logic                         halted
);

    localparam int unsigned StepW = $clog2(MAX_STEPS);

    localparam logic [15:0] CwHlt = 16'h8000;
    localparam logic [15:0] CwMi  = 16'h4000;
    localparam logic [15:0] CwRi  = 16'h2000;
    localparam logic [15:0] CwRo  = 16'h1000;
    localparam logic [15:0] CwIo  = 16'h0800;
    localparam logic [15:0] CwIi  = 16'h0400;
    localparam logic [15:0] CwAi  = 16'h0200;
    localparam logic [15:0] CwAo  = 16'h0100;
    localparam logic [15:0] CwEo  = 16'h0080;
    localparam logic [15:0] CwSu  = 16'h0040;
    localparam logic [15:0] CwBi  = 16'h0020;
    localparam logic [15:0] CwOi  = 16'h0010;
    localparam logic [15:0] CwCe  = 16'h0008;
    localparam logic [15:0] CwCo  = 16'h0004;
    localparam logic [15:0] CwJ   = 16'h0002;
    localparam logic [15:0] CwFi  = 16'h0001;

    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    localparam logic [StepW-1:0] StepT0   = StepW'(0);
    localparam logic [StepW-1:0] StepT1   = StepW'(1);
    localparam logic [StepW-1:0] StepT2   = StepW'(2);
    localparam logic [StepW-1:0] StepT3   = StepW'(3);
    localparam logic [StepW-1:0] StepT4   = StepW'(4);
    localparam logic [StepW-1:0] StepLast = StepW'(MAX_STEPS - 1);

    logic [StepW-1:0] step_q, step_d;
    logic             halted_q, halted_d;

    logic             is_unknown;
    logic             is_hlt;
    logic             halt_now;
    logic             end_cond;
    logic [StepW-1:0] last_step;
    logic [15:0]      word;

    assign is_unknown = (opcode >= 4'h9) && (opcode <= 4'hD);
    assign is_hlt     = (opcode == OpHlt) || (HALT_ON_UNKNOWN && is_unknown);
    assign halt_now   = is_hlt && (step_q == StepT2);

    always_comb begin
        last_step = StepT2;
        case (opcode)
            OpLda, OpSta: last_step = StepT3;
            OpAdd, OpSub: last_step = StepT4;
            default:      last_step = StepT2;
        endcase
    end

    // Variable-length mode uses >= so a mid-instruction opcode change cannot strand the counter.
    assign end_cond = FIXED_LEN ? (step_q == StepLast) : (step_q >= last_step);

    always_comb begin
        word = 16'h0000;
        if (step_q == StepT0) begin
            word = CwCo | CwMi;
        end else if (step_q == StepT1) begin
            word = CwRo | CwIi | CwCe;
        end else if (step_q == StepT2) begin
            case (opcode)
                OpLda, OpAdd, OpSub, OpSta: word = CwIo | CwMi;
                OpLdi:   word = CwIo | CwAi;
                OpJmp:   word = CwIo | CwJ;
                OpJc:    word = carry_f ? (CwIo | CwJ) : 16'h0000;
                OpJz:    word = zero_f ? (CwIo | CwJ) : 16'h0000;
                OpOut:   word = CwAo | CwOi;
                default: word = is_hlt ? CwHlt : 16'h0000;
            endcase
        end else if (step_q == StepT3) begin
            case (opcode)
                OpLda:        word = CwRo | CwAi;
                OpAdd, OpSub: word = CwRo | CwBi;
                OpSta:        word = CwAo | CwRi;
                default:      word = 16'h0000;
            endcase
        end else if (step_q == StepT4) begin
            case (opcode)
                OpAdd:   word = CwEo | CwAi | CwFi;
                OpSub:   word = CwEo | CwSu | CwAi | CwFi;
                default: word = 16'h0000;
            endcase
        end
    end

    always_comb begin
        out        = 16'h0000;
        instr_done = 1'b0;
        if (halted_q) begin
            out = CwHlt;
        end else if (en) begin
            out        = word;
            instr_done = end_cond;
        end
    end

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (en && !halted_q) begin
            if (halt_now) begin
                halted_d = 1'b1;
            end else if (end_cond) begin
                step_d = StepT0;
            end else begin
                step_d = step_q + StepW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_q   <= StepT0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer: instance A uses default parameters, instance B uses
// FIXED_LEN=1, MAX_STEPS=6, HALT_ON_UNKNOWN=1.
module tb_sap_sequencer;

    logic        clk;
    logic        rst_a, en_a, c_a, z_a;
    logic [3:0]  op_a;
    logic [15:0] out_a;
    logic [2:0]  step_a;
    logic        done_a, halt_a;

    logic        rst_b, en_b, c_b, z_b;
    logic [3:0]  op_b;
    logic [15:0] out_b;
    logic [2:0]  step_b;
    logic        done_b, halt_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sap_sequencer u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .en         (en_a),
        .opcode     (op_a),
        .carry_f    (c_a),
        .zero_f     (z_a),
        .out        (out_a),
        .step       (step_a),
        .instr_done (done_a),
        .halted     (halt_a)
    );

    sap_sequencer #(
        .MAX_STEPS       (6),
        .FIXED_LEN       (1'b1),
        .HALT_ON_UNKNOWN (1'b1)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .en         (en_b),
        .opcode     (op_b),
        .carry_f    (c_b),
        .zero_f     (z_b),
        .out        (out_b),
        .step       (step_b),
        .instr_done (done_b),
        .halted     (halt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; en_a = 1'b1; op_a = 4'h1; c_a = 1'b0; z_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b1; op_b = 4'h6; c_b = 1'b0; z_b = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (step_a !== 3'd0) $display("FAIL reset_step: got %0d want 0", step_a);
        else pass_cnt++;
        total_cnt++;
        if (halt_a !== 1'b0) $display("FAIL reset_halted: got %b want 0", halt_a);
        else pass_cnt++;
        total_cnt++;
        if (out_a !== 16'h4004) $display("FAIL reset_out: got %h want 4004", out_a);
        else pass_cnt++;
        total_cnt++;
        if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a);
        else pass_cnt++;
        rst_a = 1'b1;
    endtask

    task automatic test_lda();
        logic [15:0] exp_o [4] = '{16'h4004, 16'h1408, 16'h4800, 16'h1200};
        logic        exp_d [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        op_a = 4'h1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (step_a !== 3'(i)) $display("FAIL lda_step[%0d]: got %0d want %0d", i, step_a, i);
            else pass_cnt++;
            total_cnt++;
            if (out_a !== exp_o[i]) $display("FAIL lda_out[%0d]: got %h want %h", i, out_a, exp_o[i]);
            else pass_cnt++;
            total_cnt++;
            if (done_a !== exp_d[i]) $display("FAIL lda_done[%0d]: got %b want %b", i, done_a, exp_d[i]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (step_a !== 3'd0) $display("FAIL lda_wrap: got %0d want 0", step_a);
        else pass_cnt++;
    endtask

    task automatic test_add_sub();
        logic [15:0] exp_add [5] = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281};
        logic [15:0] exp_sub [5] = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1};
        op_a = 4'h2;
        #1;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_a !== exp_add[i]) $display("FAIL add_out[%0d]: got %h want %h", i, out_a, exp_add[i]);
            else pass_cnt++;
            total_cnt++;
            if (done_a !== (i == 4)) $display("FAIL add_done[%0d]: got %b want %b", i, done_a, (i == 4));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (step_a !== 3'd0) $display("FAIL add_wrap: got %0d want 0", step_a);
        else pass_cnt++;
        op_a = 4'h3;
        #1;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_a !== exp_sub[i]) $display("FAIL sub_out[%0d]: got %h want %h", i, out_a, exp_sub[i]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (step_a !== 3'd0) $display("FAIL sub_wrap: got %0d want 0", step_a);
        else pass_cnt++;
    endtask

    task automatic test_cond_jump();
        // Carry high during fetch but low at T2: must not jump.
        op_a = 4'h7; c_a = 1'b1;
        tick(); tick();
        c_a = 1'b0;
        #1;
        total_cnt++;
        if (out_a !== 16'h0000) $display("FAIL jc_nc_out: got %h want 0000", out_a);
        else pass_cnt++;
        total_cnt++;
        if (done_a !== 1'b1) $display("FAIL jc_nc_done: got %b want 1", done_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (step_a !== 3'd0) $display("FAIL jc_nc_wrap: got %0d want 0", step_a);
        else pass_cnt++;
        tick(); tick();
        c_a = 1'b1;
        #1;
        total_cnt++;
        if (out_a !== 16'h0802) $display("FAIL jc_c_out: got %h want 0802", out_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (step_a !== 3'd0) $display("FAIL jc_c_wrap: got %0d want 0", step_a);
        else pass_cnt++;
        c_a = 1'b0; op_a = 4'h8; z_a = 1'b1;
        tick(); tick();
        total_cnt++;
        if (out_a !== 16'h0802) $display("FAIL jz_out: got %h want 0802", out_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (step_a !== 3'd0) $display("FAIL jz_wrap: got %0d want 0", step_a);
        else pass_cnt++;
        z_a = 1'b0;
    endtask

    task automatic test_short_ops();
        logic [3:0]  ops   [4] = '{4'h5, 4'hE, 4'h0, 4'h9};
        logic [15:0] exp_o [4] = '{16'h0A00, 16'h0110, 16'h0000, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            op_a = ops[i];
            tick(); tick();
            total_cnt++;
            if (out_a !== exp_o[i]) $display("FAIL short_out[%h]: got %h want %h", ops[i], out_a, exp_o[i]);
            else pass_cnt++;
            total_cnt++;
            if (done_a !== 1'b1) $display("FAIL short_done[%h]: got %b want 1", ops[i], done_a);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (step_a !== 3'd0 || halt_a !== 1'b0)
                $display("FAIL short_wrap[%h]: got step %0d halted %b want 0 0", ops[i], step_a, halt_a);
            else pass_cnt++;
        end
    endtask

    task automatic test_halt();
        op_a = 4'hF;
        tick(); tick();
        total_cnt++;
        if (out_a !== 16'h8000 || halt_a !== 1'b0 || done_a !== 1'b1)
            $display("FAIL hlt_t2: got out %h halted %b done %b want 8000 0 1", out_a, halt_a, done_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (halt_a !== 1'b1) $display("FAIL hlt_latch: got %b want 1", halt_a);
        else pass_cnt++;
        total_cnt++;
        if (done_a !== 1'b0) $display("FAIL hlt_done: got %b want 0", done_a);
        else pass_cnt++;
        op_a = 4'h1;
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (step_a !== 3'd2 || out_a !== 16'h8000)
                $display("FAIL hlt_hold[%0d]: got step %0d out %h want 2 8000", i, step_a, out_a);
            else pass_cnt++;
            tick();
        end
        rst_a = 1'b0;
        tick();
        total_cnt++;
        if (step_a !== 3'd0 || halt_a !== 1'b0 || out_a !== 16'h4004)
            $display("FAIL hlt_reset: got step %0d halted %b out %h want 0 0 4004", step_a, halt_a, out_a);
        else pass_cnt++;
        rst_a = 1'b1;
    endtask

    task automatic test_stall();
        op_a = 4'h4;
        tick(); tick(); tick();
        en_a = 1'b0;
        #1;
        total_cnt++;
        if (out_a !== 16'h0000 || done_a !== 1'b0)
            $display("FAIL stall_out: got out %h done %b want 0000 0", out_a, done_a);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (step_a !== 3'd3 || out_a !== 16'h0000)
                $display("FAIL stall_hold[%0d]: got step %0d out %h want 3 0000", i, step_a, out_a);
            else pass_cnt++;
        end
        en_a = 1'b1;
        #1;
        total_cnt++;
        if (out_a !== 16'h2100 || done_a !== 1'b1)
            $display("FAIL stall_release: got out %h done %b want 2100 1", out_a, done_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (step_a !== 3'd0) $display("FAIL stall_wrap: got %0d want 0", step_a);
        else pass_cnt++;
    endtask

    task automatic test_fixed_len();
        logic [15:0] exp_o [6] = '{16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000, 16'h0000};
        rst_b = 1'b1;
        op_b  = 4'h6;
        #1;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (step_b !== 3'(i)) $display("FAIL fix_step[%0d]: got %0d want %0d", i, step_b, i);
            else pass_cnt++;
            total_cnt++;
            if (out_b !== exp_o[i]) $display("FAIL fix_out[%0d]: got %h want %h", i, out_b, exp_o[i]);
            else pass_cnt++;
            total_cnt++;
            if (done_b !== (i == 5)) $display("FAIL fix_done[%0d]: got %b want %b", i, done_b, (i == 5));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (step_b !== 3'd0) $display("FAIL fix_wrap: got %0d want 0", step_b);
        else pass_cnt++;
        tick(); tick(); tick(); tick();
        total_cnt++;
        if (step_b !== 3'd4) $display("FAIL fix_pre_rst: got %0d want 4", step_b);
        else pass_cnt++;
        rst_b = 1'b0;
        tick();
        total_cnt++;
        if (step_b !== 3'd0) $display("FAIL fix_mid_rst: got %0d want 0", step_b);
        else pass_cnt++;
        rst_b = 1'b1;
        op_b  = 4'h9;
        tick(); tick();
        total_cnt++;
        if (out_b !== 16'h8000 || done_b !== 1'b0)
            $display("FAIL fix_unk_t2: got out %h done %b want 8000 0", out_b, done_b);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (halt_b !== 1'b1 || step_b !== 3'd2)
            $display("FAIL fix_unk_halt: got halted %b step %0d want 1 2", halt_b, step_b);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_cond_jump();
        test_short_ops();
        test_halt();
        test_stall();
        test_fixed_len();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
